axis_upsizer: RTL and testbench

AXI Stream width up-converter placed directly downstream of the 8-bit stream FIFO. It packs RATIO consecutive narrow slave beats into one wide master beat, first beat in the lowest lane. It flushes a partial word on tlast with tkeep marking the valid lanes. It feeds 32-bit consumers (DMA/packet engines) at full throughput with one registered output stage.

---
 rtl/axis_pkg.sv | 26 ++
 rtl/axis_upsizer.sv | 87 ++++++++
 tb/tb_axis_upsizer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: lane-index sizing, contiguous keep masks and
// the upsizer's FILL/HOLD state type.
package axis_pkg;

    localparam int unsigned MAX_RATIO = 64;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } up_state_t;

    function automatic int unsigned lane_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Ones in bits [lane:0], zeros above.
    function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned lane);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_RATIO; i++) begin
            if (i <= lane) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_upsizer.sv
// AXI-Stream width up-converter: packs RATIO narrow beats into one wide beat,
// lowest lane first, flushing a partial word with tkeep on tlast.
module axis_upsizer
    import axis_pkg::*;
#(
    parameter  int unsigned S_DATA_WIDTH = 8,
    parameter  int unsigned RATIO        = 4,
    localparam int unsigned M_DATA_WIDTH = S_DATA_WIDTH * RATIO
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                    s_axis_tvalid_i,
    input  logic                    s_axis_tlast_i,
    output logic                    s_axis_tready_o,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [RATIO-1:0]        m_axis_tkeep_o,
    output logic                    m_axis_tvalid_o,
    output logic                    m_axis_tlast_o,
    input  logic                    m_axis_tready_i
);

    localparam int unsigned LANE_W = lane_width(RATIO);

    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || RATIO > MAX_RATIO) begin : g_bad_ratio
        $error("axis_upsizer: RATIO must be a power of two in [2, %0d]", MAX_RATIO);
    end

    up_state_t               state_q;
    logic [LANE_W-1:0]       lane_q;
    logic [M_DATA_WIDTH-1:0] data_q, data_d;
    logic [RATIO-1:0]        keep_q, keep_d;
    logic                    last_q, last_d;
    logic                    accept;
    logic                    done;

    assign s_axis_tready_o = !rst_i && (state_q == FILL || m_axis_tready_i);
    assign accept          = s_axis_tvalid_i && s_axis_tready_o;
    assign done            = (lane_q == LANE_W'(RATIO - 1)) || s_axis_tlast_i;

    // Lane 0 starts a fresh word, so stale lanes from the previous word are
    // zeroed before the new beat is placed.
    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        last_d = last_q;
        if (accept) begin
            if (lane_q == '0) data_d = '0;
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (k == int'(lane_q)) data_d[k*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata_i;
            end
            keep_d = RATIO'(keep_mask(int'(lane_q)));
            last_d = s_axis_tlast_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            lane_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
            if (accept) begin
                if (done) begin
                    state_q <= HOLD;
                    lane_q  <= '0;
                end else begin
                    state_q <= FILL;
                    lane_q  <= lane_q + LANE_W'(1);
                end
            end else if (state_q == HOLD && m_axis_tready_i) begin
                state_q <= FILL;
            end
        end
    end

    assign m_axis_tdata_o  = data_q;
    assign m_axis_tkeep_o  = keep_q;
    assign m_axis_tlast_o  = last_q;
    assign m_axis_tvalid_o = (state_q == HOLD);

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer: directed cases plus randomized
// valid/ready traffic against a queue-based packing model.
module tb_axis_upsizer;

    localparam int unsigned SW = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned MW = SW * R;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [MW-1:0] m_data;
    logic [R-1:0]  m_keep;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b1;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    bit          rand_ready = 1'b0;

    typedef struct {
        logic [MW-1:0] d;
        logic [R-1:0]  k;
        logic          l;
    } word_t;

    word_t         exp_q[$];
    word_t         got_q[$];
    logic [SW-1:0] pend[$];

    logic          prev_hold = 1'b0;
    word_t         prev_w;

    axis_upsizer #(.S_DATA_WIDTH(SW), .RATIO(R)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .s_axis_tdata_i  (s_data),
        .s_axis_tvalid_i (s_valid),
        .s_axis_tlast_i  (s_last),
        .s_axis_tready_o (s_ready),
        .m_axis_tdata_o  (m_data),
        .m_axis_tkeep_o  (m_keep),
        .m_axis_tvalid_o (m_valid),
        .m_axis_tlast_o  (m_last),
        .m_axis_tready_i (m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model and monitor, evaluated mid-cycle when everything is settled.
    always @(negedge clk) begin
        word_t w;
        if (rst) begin
            pend.delete();
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            check_eq("s_ready_rule", s_ready, !m_valid || m_ready);
            if (prev_hold) begin
                check_eq("hold_valid", m_valid, 1'b1);
                check_eq("hold_data", m_data, prev_w.d);
                check_eq("hold_keep", m_keep, prev_w.k);
                check_eq("hold_last", m_last, prev_w.l);
            end
            if (m_valid && m_ready) begin
                w.d = m_data; w.k = m_keep; w.l = m_last;
                got_q.push_back(w);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_word", 1'b1, 1'b0);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check_eq("model_data", m_data, e.d);
                    check_eq("model_keep", m_keep, e.k);
                    check_eq("model_last", m_last, e.l);
                end
            end
            if (s_valid && s_ready) begin
                pend.push_back(s_data);
                if (pend.size() == R || s_last) begin
                    w.d = '0;
                    for (int i = 0; i < pend.size(); i++) w.d = w.d | (MW'(pend[i]) << (SW * i));
                    w.k = R'((1 << pend.size()) - 1);
                    w.l = s_last;
                    exp_q.push_back(w);
                    pend.delete();
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_w.d = m_data; prev_w.k = m_keep; prev_w.l = m_last;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) #1 m_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [SW-1:0] d, input logic l);
        bit acc;
        int unsigned n;
        s_data = d; s_last = l; s_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 2000) begin
                check_eq("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_words(input int unsigned n);
        int unsigned t;
        t = 0;
        while (got_q.size() < n && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (got_q.size() < n) check_eq("word_timeout", got_q.size(), n);
    endtask

    task automatic check_word(input string tag, input int unsigned i,
                              input logic [MW-1:0] d, input logic [R-1:0] k, input logic l);
        if (got_q.size() <= i) begin
            check_eq({tag, "_missing"}, got_q.size(), i + 1);
        end else begin
            check_eq({tag, "_data"}, got_q[i].d, d);
            check_eq({tag, "_keep"}, got_q[i].k, k);
            check_eq({tag, "_last"}, got_q[i].l, l);
        end
    endtask

    initial begin
        int unsigned t0;
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", s_ready, 1'b0);
        check_eq("rst_valid", m_valid, 1'b0);
        check_eq("rst_data", m_data, '0);
        check_eq("rst_keep", m_keep, '0);
        check_eq("rst_last", m_last, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", s_ready, 1'b1);
        @(posedge clk); #1;

        // Full words, back to back
        got_q.delete();
        t0 = cyc;
        for (int i = 1; i <= 8; i++) send(SW'(i), i == 8);
        check_eq("throughput_cycles", cyc - t0, 8);
        @(negedge clk);
        check_eq("latency_valid", m_valid, 1'b1);
        check_eq("latency_data", m_data, 32'h08070605);
        wait_words(2);
        check_word("full0", 0, 32'h04030201, 4'hF, 1'b0);
        check_word("full1", 1, 32'h08070605, 4'hF, 1'b1);

        // Partial flushes
        @(posedge clk); #1;
        got_q.delete();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        send(8'hCC, 1'b1);
        wait_words(2);
        check_word("part2", 0, 32'h0000BBAA, 4'h3, 1'b1);
        check_word("part1", 1, 32'h000000CC, 4'h1, 1'b1);

        // Backpressure
        @(posedge clk); #1;
        got_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(SW'(8'h21 + i), 1'b0);
        s_data = 8'h11; s_last = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_ready_low", s_ready, 1'b0);
            check_eq("bp_data", m_data, 32'h24232221);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", s_ready, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        send(8'h14, 1'b1);
        wait_words(2);
        check_word("bp_held", 0, 32'h24232221, 4'hF, 1'b0);
        check_word("bp_next", 1, 32'h14131211, 4'hF, 1'b1);

        // Reset mid-word
        @(posedge clk); #1;
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready", s_ready, 1'b0);
        @(posedge clk); #1;
        check_eq("midrst_valid", m_valid, 1'b0);
        check_eq("midrst_data", m_data, '0);
        check_eq("midrst_keep", m_keep, '0);
        rst = 1'b0;
        got_q.delete();
        for (int i = 0; i < 4; i++) send(SW'(8'h10 + i), 1'b0);
        wait_words(1);
        check_word("after_rst", 0, 32'h13121110, 4'hF, 1'b0);

        // Randomized traffic against the model
        @(posedge clk); #1;
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(SW'($urandom), (i == 9999) || ($urandom_range(0, 9) == 0));
        end
        rand_ready = 1'b0;
        #1 m_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("drain_exp_empty", exp_q.size(), 0);
        check_eq("drain_pend_empty", pend.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
